// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze with timeout.
// Optional perf counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RDaddr_i,
  input  logic [4:0]  IFID_RS1addr_i,
  input  logic [4:0]  IFID_RS2addr_i,
  input  logic        Branch_i,
  input  logic        MemReq_i,
  input  logic        MemAck_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        NoOp_o,
  output logic        Freeze_o,
  output logic        Err_o,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        load_use;
  logic        mem_pending;

  assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));
  assign mem_pending = MemReq_i && !MemAck_i;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    IFIDFlush_o = 1'b0;
    NoOp_o      = 1'b0;
    Freeze_o    = 1'b1;
    Err_o       = (state_q == ERROR);
    if (start_i) begin
      unique case (state_q)
        RUN: begin
          if (mem_pending) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end else begin
            Freeze_o = 1'b0;
            if (load_use) begin
              NoOp_o = 1'b1;
            end else begin
              PCWrite_o   = 1'b1;
              IFIDWrite_o = 1'b1;
              IFIDFlush_o = Branch_i;
            end
          end
        end
        MEM_WAIT: begin
          // Ack wins over a coincident timeout.
          if (MemAck_i) begin
            state_d = RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (wait_cnt_d == TIMEOUT_C) state_d = ERROR;
          end
        end
        ERROR: state_d = ERROR;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_i && !PCWrite_o) stall_cnt_d = stall_cnt_q + 32'd1;
    if (IFIDFlush_o)           flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`else
  assign StallCnt_o = '0;
  assign FlushCnt_o = '0;
`endif

endmodule
